// File: rtl/width_16to8.sv
// width_16to8: serialises 16-bit words onto an 8-bit valid/ready byte stream.
//
// Handshake: a word transfers on a rising edge where valid_in && ready_in; a
// byte transfers on a rising edge where valid_out && ready_out. While a byte
// is offered and not taken, valid_out and data_out stay stable. ready_in is
// the only combinational output and depends only on state and ready_out.
module width_16to8 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [15:0] data_in,
   output logic        ready_in,
   output logic        valid_out,
   output logic [7:0]  data_out,
   input  logic        ready_out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FIRST  = 2'd1;
   localparam logic [1:0] ST_SECOND = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] buf_q, buf_d;
   logic [7:0]  data_q, data_d;
   logic        accept;

   function automatic logic [7:0] first_byte(input logic [15:0] w);
      return MSB_FIRST ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] second_byte(input logic [15:0] w);
      return MSB_FIRST ? w[7:0] : w[15:8];
   endfunction

   // Upstream ready: open when idle or when the last byte is leaving; gated off in reset.
   always_comb begin
      ready_in = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE:   ready_in = 1'b1;
            ST_SECOND: ready_in = ready_out;
            default:   ready_in = 1'b0;
         endcase
      end
   end

   assign accept = valid_in && ready_in;

   // Next-state logic: load a word, step through its two bytes, chain the next word without a bubble.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               buf_d   = data_in;
               data_d  = first_byte(data_in);
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (ready_out) begin
               data_d  = second_byte(buf_q);
               state_d = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (ready_out) begin
               if (accept) begin
                  buf_d   = data_in;
                  data_d  = first_byte(data_in);
                  state_d = ST_FIRST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, word buffer and output byte registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         buf_q   <= 16'h0000;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
      end
   end

   assign valid_out = (state_q != ST_IDLE);
   assign data_out  = data_q;

endmodule

// File: tb/tb_width_16to8.sv
// tb_width_16to8: two instances (MSB-first and LSB-first) share one stimulus
// stream; a scoreboard records expected bytes per accepted word and a monitor
// compares every transferred byte, plus directed checks of the key scenarios.
module tb_width_16to8;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] data_in;
  logic        ready_out;
  logic        ready_in_m, valid_out_m;
  logic [7:0]  data_out_m;
  logic        ready_in_l, valid_out_l;
  logic [7:0]  data_out_l;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  int words_since_rst = 0;
  int bytes_since_rst = 0;

  width_16to8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in_m), .valid_out(valid_out_m), .data_out(data_out_m),
    .ready_out(ready_out)
  );

  width_16to8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in_l), .valid_out(valid_out_l), .data_out(data_out_l),
    .ready_out(ready_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic       stall_m, stall_l;
    logic [7:0] held_m, held_l;
    stall_m = 1'b0;
    stall_l = 1'b0;
    held_m  = 8'h00;
    held_l  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_m_q.delete();
        exp_l_q.delete();
        words_since_rst = 0;
        bytes_since_rst = 0;
        stall_m = 1'b0;
        stall_l = 1'b0;
      end else begin
        if (stall_m) chk("hold_m", {7'd0, valid_out_m, data_out_m}, {7'd0, 1'b1, held_m});
        if (stall_l) chk("hold_l", {7'd0, valid_out_l, data_out_l}, {7'd0, 1'b1, held_l});
        chk("ready_match", {15'd0, ready_in_l}, {15'd0, ready_in_m});
        if (valid_out_m && ready_out) begin
          bytes_since_rst++;
          if (exp_m_q.size() == 0) chk("unexpected_m", {8'h00, data_out_m}, 16'hXXXX);
          else chk("byte_m", {8'h00, data_out_m}, {8'h00, exp_m_q.pop_front()});
        end
        if (valid_out_l && ready_out) begin
          if (exp_l_q.size() == 0) chk("unexpected_l", {8'h00, data_out_l}, 16'hXXXX);
          else chk("byte_l", {8'h00, data_out_l}, {8'h00, exp_l_q.pop_front()});
        end
        if (valid_in && ready_in_m) begin
          words_since_rst++;
          exp_m_q.push_back(data_in[15:8]);
          exp_m_q.push_back(data_in[7:0]);
        end
        if (valid_in && ready_in_l) begin
          exp_l_q.push_back(data_in[7:0]);
          exp_l_q.push_back(data_in[15:8]);
        end
        stall_m = valid_out_m && !ready_out;
        stall_l = valid_out_l && !ready_out;
        held_m  = data_out_m;
        held_l  = data_out_l;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] words[3];
  logic [7:0]  stream_bytes[6];
  logic        took;
  int          wi;
  int          drain;

  initial begin
    fork
      monitor();
    join_none

    rst_n = 1'b0; valid_in = 1'b0; data_in = 16'h0000; ready_out = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready_in", {15'd0, ready_in_m}, 16'h0000);
    drive_edge();
    @(negedge clk);
    chk("rst_valid_out", {15'd0, valid_out_m}, 16'h0000);
    chk("rst_data_out", {8'h00, data_out_m}, 16'h0000);
    drive_edge();
    rst_n = 1'b1;

    // Single word, both byte orders
    valid_in = 1'b1; data_in = 16'hA55A;
    @(negedge clk);
    chk("single_ready", {15'd0, ready_in_m}, 16'h0001);
    drive_edge();
    valid_in = 1'b0;
    @(negedge clk);
    chk("single_b0", {7'd0, valid_out_m, data_out_m}, 16'h01A5);
    chk("single_b0_l", {8'h00, data_out_l}, 16'h005A);
    chk("first_ready", {15'd0, ready_in_m}, 16'h0000);
    drive_edge();
    @(negedge clk);
    chk("single_b1", {7'd0, valid_out_m, data_out_m}, 16'h015A);
    chk("single_b1_l", {8'h00, data_out_l}, 16'h00A5);
    drive_edge();
    @(negedge clk);
    chk("single_idle", {7'd0, valid_out_m, data_out_m}, 16'h005A);
    drive_edge();

    // Streaming three words back-to-back
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
    for (int k = 0; k < 3; k++) begin
      stream_bytes[2*k]   = words[k][15:8];
      stream_bytes[2*k+1] = words[k][7:0];
    end
    wi = 0; valid_in = 1'b1; data_in = words[0];
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("stream_ready", {15'd0, ready_in_m}, (c % 2 == 0) ? 16'h0001 : 16'h0000);
      if (c >= 1) chk("stream_byte", {7'd0, valid_out_m, data_out_m}, {7'd0, 1'b1, stream_bytes[c-1]});
      took = valid_in && ready_in_m;
      drive_edge();
      if (took) begin
        wi++;
        if (wi < 3) data_in = words[wi];
        else valid_in = 1'b0;
      end
    end

    // Backpressure with an ignored upstream word while busy
    valid_in = 1'b1; data_in = 16'hBEEF; ready_out = 1'b0;
    @(negedge clk);
    chk("bp_accept", {15'd0, ready_in_m}, 16'h0001);
    drive_edge();
    data_in = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_first", {7'd0, valid_out_m, data_out_m}, 16'h01BE);
      chk("bp_first_rdy", {15'd0, ready_in_m}, 16'h0000);
      drive_edge();
      if (k == 1) valid_in = 1'b0;
      if (k == 2) ready_out = 1'b1;
      if (k == 3) begin ready_out = 1'b0; valid_in = 1'b1; data_in = 16'hFFFF; end
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("bp_second", {7'd0, valid_out_m, data_out_m}, 16'h01EF);
      chk("bp_second_rdy", {15'd0, ready_in_m}, 16'h0000);
      drive_edge();
      if (j == 1) begin valid_in = 1'b0; ready_out = 1'b1; end
    end
    @(negedge clk);
    chk("bp_release", {7'd0, valid_out_m, data_out_m}, 16'h01EF);
    chk("bp_release_rdy", {15'd0, ready_in_m}, 16'h0001);
    drive_edge();
    @(negedge clk);
    chk("bp_idle", {7'd0, valid_out_m, data_out_m}, 16'h00EF);
    drive_edge();

    // LSB-first order on CAFE
    valid_in = 1'b1; data_in = 16'hCAFE;
    @(negedge clk);
    drive_edge();
    valid_in = 1'b0;
    @(negedge clk);
    chk("lsb_b0", {8'h00, data_out_l}, 16'h00FE);
    chk("msb_b0", {8'h00, data_out_m}, 16'h00CA);
    drive_edge();
    @(negedge clk);
    chk("lsb_b1", {8'h00, data_out_l}, 16'h00CA);
    chk("msb_b1", {8'h00, data_out_m}, 16'h00FE);
    drive_edge();

    // Reset in the middle of a word
    valid_in = 1'b1; data_in = 16'hDEAD;
    @(negedge clk);
    drive_edge();
    valid_in = 1'b0; ready_out = 1'b0;
    @(negedge clk);
    chk("mid_first", {7'd0, valid_out_m, data_out_m}, 16'h01DE);
    drive_edge();
    rst_n = 1'b0; ready_out = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {15'd0, ready_in_m}, 16'h0000);
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_rst", {7'd0, valid_out_m, data_out_m}, 16'h0000);
    drive_edge();
    valid_in = 1'b1; data_in = 16'h0102;
    @(negedge clk);
    drive_edge();
    valid_in = 1'b0;
    @(negedge clk);
    chk("post_rst_b0", {7'd0, valid_out_m, data_out_m}, 16'h0101);
    drive_edge();
    @(negedge clk);
    chk("post_rst_b1", {7'd0, valid_out_m, data_out_m}, 16'h0102);
    drive_edge();

    // Randomised traffic, checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      valid_in  = ($urandom_range(0, 99) < 60);
      data_in   = 16'($urandom_range(0, 65535));
      ready_out = ($urandom_range(0, 99) < 70);
      drive_edge();
    end

    // Drain
    valid_in = 1'b0; ready_out = 1'b1;
    drain = 0;
    while ((exp_m_q.size() != 0 || valid_out_m) && drain < 10) begin
      drive_edge();
      drain++;
    end
    drive_edge();
    @(negedge clk);
    drive_edge();
    chk("drain_empty_m", 16'(exp_m_q.size()), 16'h0000);
    chk("drain_empty_l", 16'(exp_l_q.size()), 16'h0000);
    chk("byte_count", 16'(bytes_since_rst), 16'(2 * words_since_rst));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/width_16to8.md
Name: width_16to8

Overview:
- Unpacks 16-bit words into a stream of 8-bit bytes. It is the inverse of the team's 8-to-16 packer.
- Sits on the return path, where 16-bit datapath results are serialised onto an 8-bit byte interface.
- Uses a valid/ready handshake on both sides. Sustains one byte per cycle while upstream and downstream are both streaming.

Parameters:
- MSB_FIRST, 1, byte order. 1: data_in[15:8] is emitted first, then data_in[7:0] (matches the packer, which places the first byte in the upper half). 0: data_in[7:0] first.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- valid_in  input  1  upstream word valid.
- data_in  input  16  upstream word.
- ready_in  output  1  block accepts data_in this cycle. A word transfers when valid_in && ready_in at the clock edge.
- valid_out  output  1  data_out holds a valid byte.
- data_out  output  8  output byte.
- ready_out  input  1  downstream accepts data_out. A byte transfers when valid_out && ready_out at the clock edge.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, word buffer=0, valid_out=0, data_out=0. ready_in is forced 0 while rst_n is low (combinational gate).
- Reset mid-operation: any buffered word and unsent byte are discarded with no partial output. valid_out=0 after the reset edge.
- States:
  - IDLE: no data held.
  - FIRST: presenting first byte.
  - SECOND: presenting second byte.
- valid_out is registered and equals (state != IDLE).
- data_out is registered.
- ready_in is combinational: 1 in IDLE; ready_out in SECOND; 0 in FIRST.
- IDLE:
  - valid_in=1: latch data_in into the 16-bit buffer, data_out <= first byte, go to FIRST.
  - Otherwise stay; data_out holds its last value.
- FIRST:
  - ready_out=1: data_out <= second byte (from buffer), go to SECOND.
  - ready_out=0: hold state and data_out.
- SECOND:
  - ready_out=1 and valid_in=1: latch new word, data_out <= its first byte, go to FIRST. This is the back-to-back path with no bubble.
  - ready_out=1 and valid_in=0: go to IDLE; valid_out=0 next cycle; data_out keeps the second byte.
  - ready_out=0: hold; ready_in=0, so no word is accepted.
- Latency: a word accepted at edge N gives its first byte valid after edge N (visible in cycle N+1). Its second byte follows one cycle after the first byte transfers.
- Throughput: 1 byte/cycle (1 word per 2 cycles) when valid_in and ready_out are held high.
- Handshake rules:
  - While valid_out=1 and ready_out=0, data_out and valid_out stay stable.
  - A byte is never dropped or duplicated.
  - valid_out never deasserts without a transfer, except on reset.
- Upstream: data_in and valid_in are sampled only when ready_in=1. Changes while ready_in=0 are ignored.
- Byte selection per MSB_FIRST:
  - MSB_FIRST=1: first byte = word[15:8], second = word[7:0].
  - MSB_FIRST=0: first byte = word[7:0], second = word[15:8].
- No combinational path from valid_in to valid_out or data_out. The only combinational path is ready_out -> ready_in.

Test Plan:
- Single word, MSB_FIRST=1: reset, then one-cycle valid_in with data_in=16'hA55A, ready_out=1 -> ready_in=1 at accept. Next cycle valid_out=1, data_out=8'hA5. Next cycle data_out=8'h5A. Then valid_out=0 with data_out held at 8'h5A.
- Streaming: words 16'h1234, 16'h5678, 16'h9ABC offered back-to-back, ready_out=1 -> bytes 12,34,56,78,9A,BC on 6 consecutive cycles with no gaps. ready_in pulses high every other cycle.
- Backpressure: word 16'hBEEF accepted, ready_out=0 for 3 cycles, then 1 -> data_out=8'hBE stable for 4 cycles, then 8'hEF. ready_in=0 throughout FIRST and while SECOND is stalled.
- Byte order, MSB_FIRST=0: data_in=16'hCAFE -> data_out=8'hFE then 8'hCA.
- Reset mid-word: accept 16'hDEAD, assert rst_n=0 during FIRST -> after the reset edge, valid_out=0 and data_out=0, and 8'hAD is never emitted. A post-reset word 16'h0102 yields 01, 02.
- Ignore while busy: in FIRST with ready_out=0, drive valid_in=1 with data_in=16'hFFFF for 2 cycles -> the word is not accepted and the buffered bytes are unchanged. The checker confirms the total byte count equals 2 × accepted words.
